// File: rtl/mul_seq_if.sv
// Operand/result bundle for the sequential multiplier.
// The acc_en request exists only when MUL_SEQ_ACC_EN is defined.
interface mul_seq_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic                 abort;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
`ifdef MUL_SEQ_ACC_EN
  logic                 acc_en;
`endif
  logic                 busy;
  logic                 done;
  logic                 valid;
  logic [2*WIDTH-1:0]   result;

  modport master (
`ifdef MUL_SEQ_ACC_EN
    output acc_en,
`endif
    output start, abort, signed_mode, a, b,
    input  busy, done, valid, result
  );

  modport slave (
`ifdef MUL_SEQ_ACC_EN
    input  acc_en,
`endif
    input  start, abort, signed_mode, a, b,
    output busy, done, valid, result
  );
endinterface

// File: rtl/mul_seq.sv
// Radix-2^DIGIT shift-add multiplier: magnitudes are multiplied, sign is fixed up in FIX.
// Define MUL_SEQ_ACC_EN to enable accumulate mode (result += product).
module mul_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  mul_seq_if.slave   bus
);

  localparam int ITER  = WIDTH / DIGIT;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  if (WIDTH < 2 || (DIGIT != 1 && DIGIT != 2 && DIGIT != 4) || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("mul_seq: illegal WIDTH/DIGIT combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
`ifdef MUL_SEQ_ACC_EN
  logic                 accm_q, accm_d;
`endif

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   pp, prod;
  logic                 busy;

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef MUL_SEQ_ACC_EN
      accm_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
`ifdef MUL_SEQ_ACC_EN
      accm_q   <= accm_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    result_d = result_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
`ifdef MUL_SEQ_ACC_EN
    accm_d   = accm_q;
`endif

    // The most negative operand negates to itself, which is its correct unsigned magnitude.
    a_mag = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    pp = '0;
    for (int k = 0; k < DIGIT; k++) begin
      if (mplier_q[k]) pp = pp + (mcand_q << k);
    end
    prod = neg_q ? -acc_q : acc_q;

    if (busy && bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state_d  = RUN;
            cnt_d    = CNT_W'(ITER - 1);
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            neg_d    = bus.signed_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            valid_d  = 1'b0;
`ifdef MUL_SEQ_ACC_EN
            accm_d   = bus.acc_en;
`endif
          end
        end
        RUN: begin
          acc_d    = acc_q + pp;
          mcand_d  = mcand_q << DIGIT;
          mplier_d = mplier_q >> DIGIT;
          cnt_d    = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = FIX;
        end
        FIX: begin
`ifdef MUL_SEQ_ACC_EN
          result_d = accm_q ? (result_q + prod) : prod;
`else
          result_d = prod;
`endif
          valid_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done_q;
  assign bus.valid  = valid_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: a DIGIT=1 and a DIGIT=4 instance at WIDTH=8, scoreboard of expected products.
module tb_mul_seq;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_seq_if #(.WIDTH(W)) if1 ();
  mul_seq_if #(.WIDTH(W)) if4 ();

  mul_seq #(.WIDTH(W), .DIGIT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  mul_seq #(.WIDTH(W), .DIGIT(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  int n_cmp = 0;
  int n_mis = 0;
  logic [2*W-1:0] exp_q [$];
`ifdef MUL_SEQ_ACC_EN
  bit acc_req = 1'b0;
`endif

  function automatic logic [2*W-1:0] model(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    int p;
    sa = a;
    sb = b;
    if (sm) p = int'(sa) * int'(sb);
    else    p = int'(a) * int'(b);
    return p[2*W-1:0];
  endfunction

  // Called at a negedge: presents a start for one cycle and queues the expected result.
  task automatic drive(input bit sel4, input bit sm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] e);
    if (sel4) begin
      if4.start = 1'b1; if4.signed_mode = sm; if4.a = a; if4.b = b;
    end else begin
      if1.start = 1'b1; if1.signed_mode = sm; if1.a = a; if1.b = b;
    end
`ifdef MUL_SEQ_ACC_EN
    if1.acc_en = acc_req;
    if4.acc_en = acc_req;
`endif
    exp_q.push_back(e);
    @(negedge clk);
    if1.start = 1'b0;
    if4.start = 1'b0;
  endtask

  // n0 = negedges already elapsed since the start edge; lat = edges from start edge to done, -1 on timeout.
  task automatic wait_done(input bit sel4, input int n0, output int lat, output int bcyc);
    lat  = -1;
    bcyc = 0;
    for (int i = n0; i < n0 + 64; i++) begin
      if (sel4 ? if4.done : if1.done) begin
        lat = i - 1;
        break;
      end
      if (sel4 ? if4.busy : if1.busy) bcyc++;
      @(negedge clk);
    end
  endtask

  function automatic logic [2*W-1:0] pop_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return '1;
  endfunction

  task automatic test_reset();
    #1;
    n_cmp++; if (if1.busy !== 1'b0)  begin n_mis++; $display("FAIL reset_busy: got %b want 0", if1.busy); end
    n_cmp++; if (if1.done !== 1'b0)  begin n_mis++; $display("FAIL reset_done: got %b want 0", if1.done); end
    n_cmp++; if (if1.valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b want 0", if1.valid); end
    n_cmp++; if (if1.result !== '0)  begin n_mis++; $display("FAIL reset_result: got %h want 0", if1.result); end
    n_cmp++; if (if4.busy !== 1'b0)  begin n_mis++; $display("FAIL reset_busy4: got %b want 0", if4.busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_start();
    int lat, bc;
    logic [2*W-1:0] e;
    drive(0, 0, 8'd3, 8'd5, model(0, 8'd3, 8'd5));
    wait_done(0, 1, lat, bc);
    e = pop_exp();
    n_cmp++; if (lat !== 9)         begin n_mis++; $display("FAIL first_lat: got %0d want 9", lat); end
    n_cmp++; if (if1.result !== e)  begin n_mis++; $display("FAIL first_result: got %h want %h", if1.result, e); end
  endtask

  task automatic test_unsigned_max();
    int lat, bc;
    logic [2*W-1:0] e;
    drive(0, 0, 8'hFF, 8'hFF, 16'hFE01);
    n_cmp++; if (if1.valid !== 1'b0) begin n_mis++; $display("FAIL umax_valid_clear: got %b want 0", if1.valid); end
    wait_done(0, 1, lat, bc);
    e = pop_exp();
    n_cmp++; if (lat !== 9)         begin n_mis++; $display("FAIL umax_lat: got %0d want 9", lat); end
    n_cmp++; if (bc !== 9)          begin n_mis++; $display("FAIL umax_busy_cycles: got %0d want 9", bc); end
    n_cmp++; if (if1.result !== e)  begin n_mis++; $display("FAIL umax_result: got %h want %h", if1.result, e); end
    n_cmp++; if (if1.valid !== 1'b1) begin n_mis++; $display("FAIL umax_valid: got %b want 1", if1.valid); end
    repeat (2) @(negedge clk);
    n_cmp++; if (if1.done !== 1'b0) begin n_mis++; $display("FAIL umax_done_pulse: got %b want 0", if1.done); end
    n_cmp++; if (if1.result !== e)  begin n_mis++; $display("FAIL umax_hold: got %h want %h", if1.result, e); end
  endtask

  task automatic test_signed();
    int lat, bc;
    logic [2*W-1:0] e;
    drive(0, 1, 8'h80, 8'h80, 16'h4000);
    wait_done(0, 1, lat, bc);
    e = pop_exp();
    n_cmp++; if (if1.result !== e) begin n_mis++; $display("FAIL signed_minmin: got %h want %h", if1.result, e); end
    drive(0, 1, 8'hFD, 8'h05, 16'hFFF1);
    wait_done(0, 1, lat, bc);
    e = pop_exp();
    n_cmp++; if (if1.result !== e) begin n_mis++; $display("FAIL signed_neg: got %h want %h", if1.result, e); end
  endtask

  task automatic test_abort_idle();
    logic [2*W-1:0] held;
    held = if1.result;
    @(negedge clk);
    if1.abort = 1'b1;
    @(negedge clk);
    if1.abort = 1'b0;
    n_cmp++; if (if1.valid !== 1'b1)  begin n_mis++; $display("FAIL abort_idle_valid: got %b want 1", if1.valid); end
    n_cmp++; if (if1.result !== held) begin n_mis++; $display("FAIL abort_idle_result: got %h want %h", if1.result, held); end
  endtask

  task automatic test_digit4();
    int lat, bc;
    logic [2*W-1:0] e;
    drive(1, 0, 8'd12, 8'd13, 16'd156);
    if4.start = 1'b1; if4.a = 8'd1; if4.b = 8'd1;
    @(negedge clk);
    if4.start = 1'b0;
    wait_done(1, 2, lat, bc);
    e = pop_exp();
    n_cmp++; if (lat !== 3)        begin n_mis++; $display("FAIL d4_lat: got %0d want 3", lat); end
    n_cmp++; if (if4.result !== e) begin n_mis++; $display("FAIL d4_result: got %h want %h", if4.result, e); end
    @(negedge clk);
    n_cmp++; if (if4.busy !== 1'b0) begin n_mis++; $display("FAIL d4_second_start_ignored: got busy %b want 0", if4.busy); end
  endtask

  task automatic test_reset_midrun();
    int seen;
    logic [2*W-1:0] e;
    drive(0, 0, 8'd100, 8'd3, 16'd300);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    e = pop_exp();
    n_cmp++; if (if1.busy !== 1'b0)  begin n_mis++; $display("FAIL rstmid_busy: got %b want 0", if1.busy); end
    n_cmp++; if (if1.valid !== 1'b0) begin n_mis++; $display("FAIL rstmid_valid: got %b want 0", if1.valid); end
    n_cmp++; if (if1.result !== '0)  begin n_mis++; $display("FAIL rstmid_result: got %h want 0", if1.result); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(negedge clk); if (if1.done) seen++; end
    n_cmp++; if (seen !== 0) begin n_mis++; $display("FAIL rstmid_no_done: got %0d pulses want 0 (exp %h dropped)", seen, e); end
  endtask

  task automatic test_abort();
    int lat, bc, seen;
    logic [2*W-1:0] e;
    drive(0, 0, 8'd9, 8'd9, 16'd81);
    wait_done(0, 1, lat, bc);
    e = pop_exp();
    n_cmp++; if (if1.result !== e) begin n_mis++; $display("FAIL abort_pre: got %h want %h", if1.result, e); end
    drive(0, 0, 8'd50, 8'd50, 16'd2500);
    @(negedge clk);
    if1.abort = 1'b1;
    @(negedge clk);
    if1.abort = 1'b0;
    void'(pop_exp());
    n_cmp++; if (if1.busy !== 1'b0)     begin n_mis++; $display("FAIL abort_busy: got %b want 0", if1.busy); end
    n_cmp++; if (if1.valid !== 1'b0)    begin n_mis++; $display("FAIL abort_valid: got %b want 0", if1.valid); end
    n_cmp++; if (if1.result !== 16'd81) begin n_mis++; $display("FAIL abort_result: got %h want 0051", if1.result); end
    seen = 0;
    repeat (12) begin if (if1.done) seen++; @(negedge clk); end
    n_cmp++; if (seen !== 0) begin n_mis++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    drive(0, 0, 8'd7, 8'd6, 16'd42);
    wait_done(0, 1, lat, bc);
    e = pop_exp();
    n_cmp++; if (if1.result !== e) begin n_mis++; $display("FAIL abort_next: got %h want %h", if1.result, e); end
  endtask

  task automatic test_back_to_back(input bit sel4);
    int lat, bc;
    logic [2*W-1:0] e, got;
    logic [W-1:0] a, b;
    bit sm;
    for (int i = 0; i < 5; i++) begin
      a  = W'($urandom_range(0, 255));
      b  = W'($urandom_range(0, 255));
      sm = 1'($urandom_range(0, 1));
      drive(sel4, sm, a, b, model(sm, a, b));
      wait_done(sel4, 1, lat, bc);
      e   = pop_exp();
      got = sel4 ? if4.result : if1.result;
      n_cmp++; if (lat !== (sel4 ? 3 : 9)) begin n_mis++; $display("FAIL b2b_lat[%0d,%0d]: got %0d", sel4, i, lat); end
      n_cmp++; if (got !== e) begin n_mis++; $display("FAIL b2b_result[%0d,%0d] sm=%0d %h*%h: got %h want %h", sel4, i, sm, a, b, got, e); end
    end
  endtask

`ifdef MUL_SEQ_ACC_EN
  task automatic test_accumulate();
    int lat, bc;
    logic [2*W-1:0] e;
    acc_req = 1'b0;
    drive(0, 0, 8'd3, 8'd4, 16'd12);
    wait_done(0, 1, lat, bc);
    e = pop_exp();
    n_cmp++; if (if1.result !== e) begin n_mis++; $display("FAIL acc_load: got %h want %h", if1.result, e); end
    acc_req = 1'b1;
    drive(0, 0, 8'd5, 8'd6, 16'd42);
    wait_done(0, 1, lat, bc);
    e = pop_exp();
    n_cmp++; if (if1.result !== e) begin n_mis++; $display("FAIL acc_sum: got %h want %h", if1.result, e); end
    drive(0, 0, 8'd10, 8'd10, 16'd142);
    @(negedge clk);
    if1.abort = 1'b1;
    @(negedge clk);
    if1.abort = 1'b0;
    void'(pop_exp());
    n_cmp++; if (if1.result !== 16'd42) begin n_mis++; $display("FAIL acc_abort: got %h want 002a", if1.result); end
    drive(0, 1, 8'hFF, 8'h02, 16'd40);
    wait_done(0, 1, lat, bc);
    e = pop_exp();
    n_cmp++; if (if1.result !== e) begin n_mis++; $display("FAIL acc_signed: got %h want %h", if1.result, e); end
    acc_req = 1'b0;
  endtask
`endif

  initial begin
    if1.start = 1'b0; if1.abort = 1'b0; if1.signed_mode = 1'b0; if1.a = '0; if1.b = '0;
    if4.start = 1'b0; if4.abort = 1'b0; if4.signed_mode = 1'b0; if4.a = '0; if4.b = '0;
`ifdef MUL_SEQ_ACC_EN
    if1.acc_en = 1'b0; if4.acc_en = 1'b0;
`endif
    test_reset();
    test_first_start();
    test_unsigned_max();
    test_signed();
    test_abort_idle();
    test_digit4();
    test_reset_midrun();
    test_abort();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
`ifdef MUL_SEQ_ACC_EN
    test_accumulate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (minimum 2).
REQ-002 SHALL have parameter DIGIT, default 1, multiplier bits retired per iteration; legal values 1, 2, 4; WIDTH SHALL be a multiple of DIGIT.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request to capture operands and begin a multiplication.
REQ-006 SHALL have port abort  input  1  cancel an operation in progress.
REQ-007 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-008 SHALL have port a  input  WIDTH  multiplicand.
REQ-009 SHALL have port b  input  WIDTH  multiplier.
REQ-010 SHALL have port busy  output  1  calculation in progress.
REQ-011 SHALL have port done  output  1  single-cycle completion pulse.
REQ-012 SHALL have port valid  output  1  result holds a completed product.
REQ-013 SHALL have port result  output  2*WIDTH  product, or running sum (REQ-031).

Function
REQ-014 SHALL have states IDLE, RUN, FIX; IDLE->RUN on start, RUN->FIX after the last iteration, FIX->IDLE unconditionally.
REQ-015 SHALL, on start high while not busy, capture a, b and signed_mode, clear valid and raise busy at that edge.
REQ-016 SHALL ignore start while busy; captured operands and timing are unaffected.
REQ-017 SHALL, in RUN, retire DIGIT multiplier bits per cycle for ITER = WIDTH/DIGIT cycles, adding shifted partial products of |a| into a 2*WIDTH accumulator.
REQ-018 SHALL, in signed mode, multiply magnitudes and negate the product in FIX when operand signs differ; the most negative operand SHALL be handled (|-2^(WIDTH-1)| fits WIDTH unsigned bits).
REQ-019 SHALL, in FIX, load result, pulse done for exactly one cycle, set valid, and drop busy at the same edge.
REQ-020 SHALL give total latency of ITER+1 cycles from the start edge to the edge raising done.
REQ-021 SHALL hold result and valid stable until the next accepted start or reset.
REQ-022 SHALL accept a start in the cycle done is high (FSM back in IDLE) with no bubble.
REQ-023 SHALL, on abort while busy, return to IDLE next edge with no done, valid low, result unchanged; abort in IDLE SHALL have no effect; abort SHALL take priority over start in the same cycle.
REQ-024 SHALL produce an exact product; the 2*WIDTH result SHALL never overflow in non-accumulate operation.

Reset
REQ-025 SHALL, while rst_n is low, asynchronously force IDLE, busy=0, done=0, valid=0, result=0, and clear the accumulator and iteration counter.
REQ-026 SHALL, on reset mid-operation, discard the operation with no done pulse after release.
REQ-027 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL provide macro MUL_SEQ_ACC_EN selecting accumulate support.
REQ-029 SHALL, with MUL_SEQ_ACC_EN defined, add port acc_en  input  1, sampled with start.
REQ-030 SHALL, with MUL_SEQ_ACC_EN undefined, have no acc_en port and always load result with the plain product.
REQ-031 SHALL, with MUL_SEQ_ACC_EN defined and acc_en=1, set result = previous result + product modulo 2^(2*WIDTH); with acc_en=0, load the plain product; abort SHALL leave the running sum unchanged.

Verification
REQ-032 SHALL cover WIDTH=8, DIGIT=1, unsigned, a=255, b=255 -> result=0xFE01, done exactly 9 cycles after the start edge, busy high for 9 cycles.
REQ-033 SHALL cover WIDTH=8, signed, a=0x80, b=0x80 -> 0x4000; a=0xFD (-3), b=5 -> 0xFFF1.
REQ-034 SHALL cover WIDTH=8, DIGIT=4, a=12, b=13 -> 156, done 3 cycles after start; a second start during busy is ignored.
REQ-035 SHALL cover rst_n low at cycle 4 of a run, and abort at cycle 3 -> no done, valid=0, next start 7*6 -> 42.
REQ-036 SHALL cover, with MUL_SEQ_ACC_EN defined, 3*4 with acc_en=0 then 5*6 with acc_en=1 -> result 12 then 42.
